// File: rtl/tick_sched_pkg.sv
// Shared definitions for the tick scheduler: channel FSM states, the
// half-period clamp applied when a config is committed, and the channel
// index width helper.
package tick_sched_pkg;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } ch_state_t;

  // A zero half-period would never wrap; treat it as one base tick.
  function automatic logic [31:0] clamp_period(input logic [31:0] p);
    return (p == 32'd0) ? 32'd1 : p;
  endfunction

  // Channel select width, at least one bit even for a single channel.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tick_channel.sv
// One scheduler channel: shadow config, state machine, base-tick counter
// and square output.
//   clk, rst_n            clock, synchronous active-low reset
//   base_tick             shared timebase pulse
//   acc                   config accepted for this channel this cycle
//   cfg_period/enable     config payload captured into the shadow on acc
//   slow_clk / tick_out   square output / pulse on each toggle
//   pending               shadow holds an accepted, unapplied update
// With TICK_SCHED_READBACK_EN defined, also exports act_period and running.
module tick_channel import tick_sched_pkg::*; #(
  parameter int PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                base_tick,
  input  logic                acc,
  input  logic [PERIOD_W-1:0] cfg_period,
  input  logic                cfg_enable,
  output logic                slow_clk,
  output logic                tick_out,
  output logic                pending
`ifdef TICK_SCHED_READBACK_EN
  ,
  output logic [PERIOD_W-1:0] act_period,
  output logic                running
`endif
);

  ch_state_t           state, state_nx;
  logic [PERIOD_W-1:0] ctr, act, sh_p;
  logic                sh_en;
  logic                wrap, fall, apply;

`ifdef TICK_SCHED_READBACK_EN
  assign act_period = act;
  assign running    = (state != OFF);
`endif

  always_comb begin
    wrap     = base_tick && (ctr == act - PERIOD_W'(1));
    // Falling toggle closes a full period: the only safe point to switch.
    fall     = wrap && slow_clk;
    apply    = 1'b0;
    state_nx = state;
    case (state)
      OFF: if (pending) begin
        apply    = 1'b1;
        state_nx = sh_en ? RUN : OFF;
      end
      RUN: if (acc) state_nx = DRAIN;
      DRAIN: if (fall) begin
        apply    = 1'b1;
        state_nx = sh_en ? RUN : OFF;
      end
      default: state_nx = OFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= OFF;
    else        state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctr      <= '0;
      act      <= '0;
      sh_p     <= '0;
      sh_en    <= 1'b0;
      slow_clk <= 1'b0;
      tick_out <= 1'b0;
      pending  <= 1'b0;
    end else begin
      tick_out <= 1'b0;
      if (acc) begin
        sh_p    <= cfg_period;
        sh_en   <= cfg_enable;
        pending <= 1'b1;
      end
      // Apply wins over counting; in DRAIN the counter is wrapping to 0 anyway.
      if (apply) begin
        act     <= PERIOD_W'(clamp_period(32'(sh_p)));
        ctr     <= '0;
        pending <= 1'b0;
      end else if (state != OFF && base_tick) begin
        ctr <= wrap ? '0 : ctr + PERIOD_W'(1);
      end
      if (state != OFF && wrap) begin
        slow_clk <= ~slow_clk;
        tick_out <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/tick_scheduler.sv
// Shared-timebase rate controller: a prescaler makes base_tick every
// CLK_FREQ/BASE_FREQ clocks; NUM_CH channels divide it into square outputs
// whose half-period/enable are set through a valid/ready config port and
// committed only at full-period boundaries.
//   clk, rst_n                     clock, synchronous active-low reset
//   cfg_valid/cfg_ready            config handshake (ready = ~pending[cfg_ch])
//   cfg_ch/cfg_period/cfg_enable   config payload
//   slow_clk, tick_out, pending    per-channel outputs
//   base_tick                      shared timebase pulse
// Optional macro TICK_SCHED_READBACK_EN adds rd_period / rd_running for
// the channel addressed by cfg_ch.
module tick_scheduler import tick_sched_pkg::*; #(
  parameter  int CLK_FREQ  = 100_000_000,
  parameter  int BASE_FREQ = 1000,
  parameter  int NUM_CH    = 4,
  parameter  int PERIOD_W  = 16,
  localparam int CH_W      = ch_width(NUM_CH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [PERIOD_W-1:0] cfg_period,
  input  logic                cfg_enable,
  output logic [NUM_CH-1:0]   slow_clk,
  output logic [NUM_CH-1:0]   tick_out,
  output logic                base_tick,
  output logic [NUM_CH-1:0]   pending
`ifdef TICK_SCHED_READBACK_EN
  ,
  output logic [PERIOD_W-1:0] rd_period,
  output logic                rd_running
`endif
);

  localparam int PRESCALE = CLK_FREQ / BASE_FREQ;
  localparam int PS_W     = $clog2(PRESCALE);

  logic [PS_W-1:0]   ps_cnt;
  logic              ps_wrap;
  logic [NUM_CH-1:0] acc;

  assign ps_wrap = (ps_cnt == PS_W'(PRESCALE - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ps_cnt    <= '0;
      base_tick <= 1'b0;
    end else begin
      ps_cnt    <= ps_wrap ? '0 : ps_cnt + PS_W'(1);
      base_tick <= ps_wrap;
    end
  end

`ifdef TICK_SCHED_READBACK_EN
  logic [NUM_CH-1:0][PERIOD_W-1:0] rd_act;
  logic [NUM_CH-1:0]               rd_run;
`endif

  // Out-of-range channel numbers see ready=1 and match no channel, so the
  // request completes and is dropped.
  always_comb begin
    cfg_ready = 1'b1;
    acc       = '0;
`ifdef TICK_SCHED_READBACK_EN
    rd_period  = '0;
    rd_running = 1'b0;
`endif
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == CH_W'(i)) begin
        cfg_ready = ~pending[i];
        acc[i]    = cfg_valid & ~pending[i];
`ifdef TICK_SCHED_READBACK_EN
        rd_period  = rd_act[i];
        rd_running = rd_run[i];
`endif
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    tick_channel #(.PERIOD_W(PERIOD_W)) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .base_tick  (base_tick),
      .acc        (acc[i]),
      .cfg_period (cfg_period),
      .cfg_enable (cfg_enable),
      .slow_clk   (slow_clk[i]),
      .tick_out   (tick_out[i]),
      .pending    (pending[i])
`ifdef TICK_SCHED_READBACK_EN
      ,
      .act_period (rd_act[i]),
      .running    (rd_run[i])
`endif
    );
  end

endmodule

// File: tb/tb_tick_scheduler.sv
// Self-checking bench for tick_scheduler (PRESCALE=10, 4 channels).
// The reference model tracks, per channel, the number of base ticks since
// the last commit; slow_clk is the parity of completed half-periods.
module tb_tick_scheduler;
  localparam int CLK_FREQ = 100, BASE_FREQ = 10, NUM_CH = 4, PERIOD_W = 16;
  localparam int PRESCALE = CLK_FREQ / BASE_FREQ;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                cfg_valid = 1'b0;
  logic                cfg_ready;
  logic [1:0]          cfg_ch = '0;
  logic [PERIOD_W-1:0] cfg_period = '0;
  logic                cfg_enable = 1'b0;
  logic [NUM_CH-1:0]   slow_clk, tick_out, pending;
  logic                base_tick;

  tick_scheduler #(.CLK_FREQ(CLK_FREQ), .BASE_FREQ(BASE_FREQ),
                   .NUM_CH(NUM_CH), .PERIOD_W(PERIOD_W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_period(cfg_period), .cfg_enable(cfg_enable),
    .slow_clk(slow_clk), .tick_out(tick_out), .base_tick(base_tick),
    .pending(pending));

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
  endtask

  // ---------------- reference model ----------------
  int m_e;            // clock edges since reset release
  bit m_bt;
  int m_n   [NUM_CH]; // base ticks since last commit
  int m_p   [NUM_CH];
  bit m_run [NUM_CH];
  bit m_pend[NUM_CH];
  bit m_tick[NUM_CH];
  int m_shp [NUM_CH];
  bit m_shen[NUM_CH];

  task automatic m_apply(input int i);
    m_p[i]    = (m_shp[i] == 0) ? 1 : m_shp[i];
    m_n[i]    = 0;
    m_run[i]  = m_shen[i];
    m_pend[i] = 1'b0;
  endtask

  function automatic bit m_slow(input int i);
    return m_run[i] && m_p[i] > 0 && ((m_n[i] / m_p[i]) % 2 == 1);
  endfunction

  always @(posedge clk) begin
    bit bt_now, acc;
    int ach;
    if (!rst_n) begin
      m_e = 0; m_bt = 0;
      for (int i = 0; i < NUM_CH; i++) begin
        m_n[i] = 0; m_p[i] = 0; m_run[i] = 0; m_pend[i] = 0;
        m_tick[i] = 0; m_shp[i] = 0; m_shen[i] = 0;
      end
    end else begin
      bt_now = m_bt;
      ach    = int'(cfg_ch);
      acc    = cfg_valid && !m_pend[ach];
      for (int i = 0; i < NUM_CH; i++) begin
        m_tick[i] = 0;
        if (!m_run[i]) begin
          if (m_pend[i]) m_apply(i);
        end else if (bt_now) begin
          m_n[i]++;
          if (m_n[i] % m_p[i] == 0) begin
            m_tick[i] = 1;
            // even number of half-periods done: output just fell
            if ((m_n[i] / m_p[i]) % 2 == 0 && m_pend[i]) m_apply(i);
          end
        end
      end
      if (acc) begin
        m_shp[ach] = int'(cfg_period); m_shen[ach] = cfg_enable; m_pend[ach] = 1;
      end
      m_e++;
      m_bt = (m_e % PRESCALE == 0);
    end
  end

  // ---------------- per-cycle comparison ----------------
  bit chk_en = 0;
  always @(negedge clk) if (chk_en) begin
    logic [NUM_CH-1:0] e_slow, e_tick, e_pend;
    for (int i = 0; i < NUM_CH; i++) begin
      e_slow[i] = m_slow(i); e_tick[i] = m_tick[i]; e_pend[i] = m_pend[i];
    end
    chk("base_tick", 32'(base_tick), 32'(m_bt));
    chk("slow_clk",  32'(slow_clk),  32'(e_slow));
    chk("tick_out",  32'(tick_out),  32'(e_tick));
    chk("pending",   32'(pending),   32'(e_pend));
    chk("cfg_ready", 32'(cfg_ready), 32'(!m_pend[int'(cfg_ch)]));
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold a request until the model says it is taken, bounded by maxwait.
  task automatic send(input int ch, input int p, input bit en, input int maxwait);
    bit taken = 0;
    cfg_ch = 2'(ch); cfg_period = PERIOD_W'(p); cfg_enable = en; cfg_valid = 1'b1;
    for (int k = 0; k < maxwait && !taken; k++) begin
      @(negedge clk);
      taken = !m_pend[ch];
      @(posedge clk); #1;
    end
    if (!taken) chk("accept_timeout", 32'(0), 32'(1));
    cfg_valid = 1'b0;
  endtask

  initial begin
    cycles(3);
    chk_en = 1;           // reset state compared from here on
    cycles(2);
    rst_n = 1'b1;
    cycles(25);           // base_tick only

    send(0, 3, 1, 10);
    cycles(100);

    send(0, 1, 1, 10);    // ch0 now draining
    send(1, 2, 1, 10);    // other channel taken at once
    send(0, 2, 1, 200);   // waits for ch0 commit
    cycles(80);

    send(2, 0, 1, 10);    // clamped to 1
    cycles(50);
    send(2, 0, 0, 200);   // stops after a full period
    cycles(50);

    for (int it = 0; it < 250; it++) begin
      cycles($urandom_range(0, 30));
      send($urandom_range(0, NUM_CH - 1), $urandom_range(0, 4),
           bit'($urandom_range(0, 3) != 0), 400);
    end
    cycles(200);

    send(0, 4, 1, 400);
    cycles(150);
    send(0, 2, 1, 10);
    cycles(5);
    rst_n = 1'b0;         // reset while ch0 drains
    cycles(3);
    rst_n = 1'b1;
    cycles(100);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
